// File: rtl/bht_update_unit.sv
// Branch-history-table updater: buffers resolved-branch events in a small FIFO and
// performs a read-modify-write of the 2-bit saturating counter for each one.
module bht_update_unit #(
    parameter int ADDRLEN    = 10,
    parameter int DATALEN    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic [ADDRLEN-1:0] upd_idx,
    input  logic               upd_taken,
    input  logic               flush,
    output logic               rd_en,
    output logic [ADDRLEN-1:0] rd_addr,
    input  logic [DATALEN-1:0] rd_data,
    output logic               wr_en,
    output logic [ADDRLEN-1:0] wr_addr,
    output logic [DATALEN-1:0] wr_data,
    output logic               busy,
    output logic [15:0]        upd_cnt
);

    localparam int PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNTW = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTRW-1:0]    PTR_ONE  = PTRW'(1);
    localparam logic [PTRW-1:0]    PTR_LAST = PTRW'(FIFO_DEPTH - 1);
    localparam logic [CNTW-1:0]    CNT_ONE  = CNTW'(1);
    localparam logic [CNTW-1:0]    CNT_FULL = CNTW'(FIFO_DEPTH);
    localparam logic [DATALEN-1:0] DATA_ONE = DATALEN'(1);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    logic [ADDRLEN:0]   mem_q [FIFO_DEPTH];
    logic [PTRW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTRW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]    count_q, count_d;
    state_t             state_q;
    logic               rd_en_q, wr_en_q;
    logic [ADDRLEN-1:0] rd_addr_q, wr_addr_q;
    logic [DATALEN-1:0] wr_data_q;
    logic [15:0]        upd_cnt_q;

    logic               fifo_empty, fifo_full, push, pop;
    logic [ADDRLEN-1:0] head_idx;
    logic               head_taken;

    function automatic logic [DATALEN-1:0] nextCounter(input logic [DATALEN-1:0] ctr,
                                                       input logic taken);
        logic [DATALEN-1:0] res;
        res = ctr;
        if (taken && (ctr != '1))
            res = ctr + DATA_ONE;
        else if (!taken && (ctr != '0))
            res = ctr - DATA_ONE;
        return res;
    endfunction

    function automatic logic [PTRW-1:0] advance(input logic [PTRW-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + PTR_ONE;
    endfunction

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CNT_FULL);
    assign head_idx   = mem_q[rd_ptr_q][ADDRLEN:1];
    assign head_taken = mem_q[rd_ptr_q][0];
    // flush wins over a simultaneous push and cancels the pop of an interrupted READ
    assign push       = upd_valid && !fifo_full && !flush;
    assign pop        = (state_q == READ) && !flush;

    always_comb begin
        wr_ptr_d = push ? advance(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? advance(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)
            count_d = count_q + CNT_ONE;
        else if (!push && pop)
            count_d = count_q - CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= {upd_idx, upd_taken};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Port strobes are registered on entry to READ/WRITE so they are glitch-free
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            upd_cnt_q <= '0;
        end else begin
            if ((state_q == WRITE) && (upd_cnt_q != 16'hFFFF))
                upd_cnt_q <= upd_cnt_q + 16'd1;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            wr_en_q   <= 1'b0;
            if (flush) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (!fifo_empty) begin
                            state_q   <= READ;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= head_idx;
                        end
                    end
                    READ: begin
                        state_q   <= WRITE;
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= rd_addr_q;
                        wr_data_q <= nextCounter(rd_data, head_taken);
                    end
                    WRITE: begin
                        if (!fifo_empty) begin
                            state_q   <= READ;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= head_idx;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign upd_ready = !fifo_full;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign wr_en     = wr_en_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign busy      = !fifo_empty || (state_q != IDLE);
    assign upd_cnt   = upd_cnt_q;

endmodule

// File: doc/bht_update_unit.md
BHT_UPDATE_UNIT -- requirements
Module: bht_update_unit

Interface
REQ-001 The block SHALL expose parameters (name, default, meaning): ADDRLEN, 10, BHT index width.
REQ-002 The block SHALL expose parameter DATALEN, 2, counter width; only 2 is supported.
REQ-003 The block SHALL expose parameter FIFO_DEPTH, 4, resolve-event buffer entries, power of two.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset, with ports:
 clk  in  1  clock; all state updates on rising edge
 rst  in  1  asynchronous active-high reset
 upd_valid  in  1  branch-resolve event valid (from EX)
 upd_ready  out  1  event accepted when upd_valid&upd_ready at clk rise
 upd_idx  in  ADDRLEN  BHT index of resolved branch
 upd_taken  in  1  1 = branch taken
 flush  in  1  discard all buffered and in-flight events
 rd_en  out  1  BHT read-port enable
 rd_addr  out  ADDRLEN  BHT read-port address
 rd_data  in  DATALEN  BHT read data, combinational from rd_addr/rd_en
 wr_en  out  1  BHT write-port enable (RAM commits on falling clk)
 wr_addr  out  ADDRLEN  BHT write-port address
 wr_data  out  DATALEN  new counter value
 busy  out  1  FIFO non-empty or FSM not IDLE
 upd_cnt  out  16  completed writes, saturating at 16'hFFFF

Function
REQ-005 Events SHALL be buffered in a FIFO_DEPTH-entry FIFO of {upd_idx, upd_taken}, stored in arrival order.
REQ-006 upd_ready SHALL be the combinational value !fifo_full; events offered while full SHALL NOT be stored.
REQ-007 A push and a pop in the same cycle SHALL leave the occupancy unchanged, and SHALL store and remove the correct entries.
REQ-008 The FSM SHALL have states IDLE, READ and WRITE.
REQ-009 In IDLE, a non-empty FIFO SHALL cause the next state to be READ; otherwise the FSM SHALL stay in IDLE.
REQ-010 In READ, the block SHALL drive rd_en=1 and rd_addr=head idx, register rd_data and the head taken bit, pop the head, and go to WRITE.
REQ-011 In WRITE, the block SHALL drive wr_en=1, wr_addr=registered idx and wr_data=new counter.
REQ-012 From WRITE, the next state SHALL be READ if the FIFO is non-empty, otherwise IDLE.
REQ-013 Counter update SHALL be saturating: taken increments toward 2'b11 and holds at 11; not-taken decrements toward 2'b00 and holds at 00.
REQ-014 Latency SHALL be: event accepted at edge N; IDLE in cycle N+1, READ in N+2, WRITE in N+3.
REQ-015 Sustained throughput SHALL be one update per 2 cycles.
REQ-016 Back-to-back events to the same index SHALL each see the prior event's result, because the write commits at the falling edge of WRITE, before the next READ; no forwarding is required.
REQ-017 Outside READ, rd_en SHALL be 0 and rd_addr SHALL be 0.
REQ-018 Outside WRITE, wr_en SHALL be 0, while wr_addr and wr_data hold their last values.
REQ-019 flush in IDLE or READ SHALL empty the FIFO and force IDLE next cycle; a READ interrupted by flush SHALL produce no write.
REQ-020 flush in WRITE SHALL let that write complete, then empty the FIFO and force IDLE.
REQ-021 flush SHALL take priority over a simultaneous push; the pushed event SHALL be dropped.
REQ-022 upd_cnt SHALL increment by 1 on every WRITE cycle and saturate at 16'hFFFF.

Reset
REQ-023 While rst=1, the block SHALL empty the FIFO, set the FSM to IDLE and clear upd_cnt, immediately and asynchronously.
REQ-024 Reset values SHALL be: rd_en=0, rd_addr=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, upd_cnt=0, upd_ready=1.
REQ-025 Reset asserted mid-operation (READ or WRITE) SHALL abort the operation with no further write after the reset edge.

Verification
REQ-026 Single event: BHT[5]=01, upd_idx=5, taken=1 at edge N -> rd_en/rd_addr=5 in N+2; wr_en=1, wr_addr=5, wr_data=10 in N+3; upd_cnt=1.
REQ-027 Saturation: BHT[7]=11 with taken=1 -> wr_data=11; BHT[7]=00 with taken=0 -> wr_data=00.
REQ-028 Same-index chain: BHT[3]=00, four back-to-back taken events to idx 3 -> wr_data sequence 01,10,11,11; BHT[3]=11 at the end.
REQ-029 Full FIFO: hold upd_valid with 6 distinct indices from idle -> upd_ready drops to 0 when 4 entries are buffered; all 6 written in order; busy=0 after the last WRITE.
REQ-030 Flush: 3 events queued, flush asserted during the first WRITE -> exactly one write occurs, then IDLE; busy=0 next cycle; upd_cnt=1.
REQ-031 Async reset asserted during READ with 2 events queued -> all outputs at reset values immediately; no wr_en pulse afterwards; upd_ready=1.
